// File: rtl/clock_mode_ctrl.sv
// Clock mode controller: debounced front-panel buttons drive the RUN/SET/DEBUG FSM,
// the field select, the increment strobe and the SET-state inactivity timeout.

module clock_mode_db #(
  parameter int DB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], btn};
    acc_d  = acc_q;
    cnt_d  = '0;
    if (sync_q[1] != acc_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) acc_d = sync_q[1];
      else                              cnt_d = cnt_q + 1'b1;
    end
  end

  // Press fires in the cycle the accepted level rises, so the FSM registers on that edge.
  assign press = acc_d & ~acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      acc_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module clock_mode_ctrl #(
  parameter int DB_CYCLES = 20000,
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_debug,
  input  logic       tick_1hz,
  output logic       debug_mode,
  output logic       set_mode,
  output logic [1:0] set_field,
  output logic       inc_pulse,
  output logic [2:0] state_o
);
  localparam int NUM_LANES = 3;
  localparam int TW        = $clog2(TIMEOUT_S + 1);

  typedef enum logic [2:0] {
    RUN = 3'd0, SET_HOUR = 3'd1, SET_MIN = 3'd2, SET_SEC = 3'd3, DEBUG = 3'd4
  } state_e;

  logic [NUM_LANES-1:0] btn_raw, press;
  logic                 p_mode, p_set, p_debug;

  assign btn_raw = {btn_debug, btn_set, btn_mode};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_db
    clock_mode_db #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_raw[i]),
      .press (press[i])
    );
  end

  assign p_mode  = press[0];
  assign p_set   = press[1];
  assign p_debug = press[2];

  state_e        state_q, state_d;
  logic [TW-1:0] to_q, to_d;
  logic          inc_q, inc_d, setm_q, setm_d, dbg_q, dbg_d;
  logic [1:0]    field_q, field_d;
  logic          in_set, next_set, timed_out;

  always_comb begin
    state_d   = state_q;
    inc_d     = 1'b0;
    in_set    = (state_q == SET_HOUR) || (state_q == SET_MIN) || (state_q == SET_SEC);
    timed_out = in_set && (to_q == TW'(TIMEOUT_S));
    case (state_q)
      RUN:      if (p_debug) state_d = DEBUG;   else if (p_mode) state_d = SET_HOUR;
      SET_HOUR: if (p_mode)  state_d = SET_MIN; else if (p_set)  inc_d   = 1'b1;
      SET_MIN:  if (p_mode)  state_d = SET_SEC; else if (p_set)  inc_d   = 1'b1;
      SET_SEC:  if (p_mode)  state_d = RUN;     else if (p_set)  inc_d   = 1'b1;
      DEBUG:    if (p_debug) state_d = RUN;
      default:  state_d = RUN;
    endcase
    // Timeout overrides whatever press arrives in the same cycle.
    if (timed_out) begin
      state_d = RUN;
      inc_d   = 1'b0;
    end

    // Counter is cleared on timeout, so it never passes TIMEOUT_S.
    to_d = to_q;
    if (!in_set || timed_out || (|press)) to_d = '0;
    else if (tick_1hz)                    to_d = to_q + 1'b1;

    next_set = (state_d == SET_HOUR) || (state_d == SET_MIN) || (state_d == SET_SEC);
    setm_d   = next_set;
    dbg_d    = (state_d == DEBUG);
    field_d  = next_set ? state_d[1:0] : 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      to_q    <= '0;
      inc_q   <= 1'b0;
      setm_q  <= 1'b0;
      dbg_q   <= 1'b0;
      field_q <= 2'd0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      inc_q   <= inc_d;
      setm_q  <= setm_d;
      dbg_q   <= dbg_d;
      field_q <= field_d;
    end
  end

  assign state_o    = state_q;
  assign set_mode   = setm_q;
  assign debug_mode = dbg_q;
  assign set_field  = field_q;
  assign inc_pulse  = inc_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: expected output-vector changes are queued with
// the stimulus and matched in order (and in time) against observed changes.
module tb_clock_mode_ctrl;
  logic       clk = 1'b0, rst_n = 1'b1;
  logic       btn_mode = 1'b0, btn_set = 1'b0, btn_debug = 1'b0, tick_1hz = 1'b0;
  logic       debug_mode, set_mode, inc_pulse;
  logic [1:0] set_field;
  logic [2:0] state_o;

  clock_mode_ctrl #(.DB_CYCLES(4), .TIMEOUT_S(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_set(btn_set),
    .btn_debug(btn_debug), .tick_1hz(tick_1hz), .debug_mode(debug_mode),
    .set_mode(set_mode), .set_field(set_field), .inc_pulse(inc_pulse), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] vec; int cyc; int tol; } exp_t;
  typedef struct { logic [7:0] vec; int cyc; } obs_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  int         n_cmp = 0, n_err = 0, cyc = 0;
  logic [7:0] prev_v = 8'h00;

  function automatic logic [7:0] outv();
    return {state_o, set_field, set_mode, debug_mode, inc_pulse};
  endfunction

  function automatic logic [7:0] ev(input logic [2:0] st, input logic [1:0] f,
                                    input logic sm, input logic dm, input logic inc);
    return {st, f, sm, dm, inc};
  endfunction

  // Advance n cycles, logging every change of the output vector with its cycle number.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; cyc++;
      if (outv() !== prev_v) begin
        obs_q.push_back('{outv(), cyc});
        prev_v = outv();
      end
    end
  endtask

  task automatic expect_ev(input logic [7:0] v, input int c, input int tol);
    exp_q.push_back('{v, c, tol});
  endtask

  task automatic press(input logic m, input logic s, input logic d);
    btn_mode = m; btn_set = s; btn_debug = d;
    step(8);
    btn_mode = 0; btn_set = 0; btn_debug = 0;
    step(10);
  endtask

  task automatic tick();
    tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(2);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0; #1;
    n_cmp++;
    if (outv() !== 8'h00) begin n_err++; $display("FAIL reset_assert: got %h want 00", outv()); end
    step(3);
    rst_n = 1'b1;
    step(5);
    n_cmp++;
    if (outv() !== 8'h00) begin n_err++; $display("FAIL reset_idle: got %h want 00", outv()); end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL reset_extra: got %0d events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_mode_enter();
    exp_t e; obs_t o;
    expect_ev(ev(3'd1, 2'd1, 1, 0, 0), cyc + 6, 1);
    btn_mode = 1'b1; step(10); btn_mode = 1'b0; step(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL mode_enter missing: got none want %h", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc < e.cyc - e.tol || o.cyc > e.cyc + e.tol) begin
          n_err++; $display("FAIL mode_enter: got %h@%0d want %h@%0d", o.vec, o.cyc, e.vec, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL mode_enter extra: got %h want none", obs_q[0].vec); obs_q.delete(); end
  endtask

  task automatic test_set_inc();
    exp_t e; obs_t o;
    btn_set = 1'b1; step(3); btn_set = 1'b0; step(10);
    expect_ev(ev(3'd1, 2'd1, 1, 0, 1), cyc + 6, 1);
    expect_ev(ev(3'd1, 2'd1, 1, 0, 0), cyc + 7, 1);
    btn_set = 1'b1; step(50); btn_set = 1'b0; step(10);
    expect_ev(ev(3'd2, 2'd2, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    expect_ev(ev(3'd3, 2'd3, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    expect_ev(ev(3'd0, 2'd0, 0, 0, 0), cyc + 6, 1); press(1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL set_inc missing: got none want %h", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc < e.cyc - e.tol || o.cyc > e.cyc + e.tol) begin
          n_err++; $display("FAIL set_inc: got %h@%0d want %h@%0d", o.vec, o.cyc, e.vec, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL set_inc extra: got %h want none", obs_q[0].vec); obs_q.delete(); end
  endtask

  task automatic test_mode_cycle();
    exp_t e; obs_t o;
    expect_ev(ev(3'd1, 2'd1, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    press(0, 0, 1);
    expect_ev(ev(3'd2, 2'd2, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    expect_ev(ev(3'd3, 2'd3, 1, 0, 0), cyc + 6, 1); press(1, 1, 0);
    expect_ev(ev(3'd0, 2'd0, 0, 0, 0), cyc + 6, 1); press(1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL mode_cycle missing: got none want %h", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc < e.cyc - e.tol || o.cyc > e.cyc + e.tol) begin
          n_err++; $display("FAIL mode_cycle: got %h@%0d want %h@%0d", o.vec, o.cyc, e.vec, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL mode_cycle extra: got %h want none", obs_q[0].vec); obs_q.delete(); end
  endtask

  task automatic test_debug();
    exp_t e; obs_t o;
    expect_ev(ev(3'd4, 2'd0, 0, 1, 0), cyc + 6, 1); press(1, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    expect_ev(ev(3'd0, 2'd0, 0, 0, 0), cyc + 6, 1); press(0, 0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL debug missing: got none want %h", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc < e.cyc - e.tol || o.cyc > e.cyc + e.tol) begin
          n_err++; $display("FAIL debug: got %h@%0d want %h@%0d", o.vec, o.cyc, e.vec, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL debug extra: got %h want none", obs_q[0].vec); obs_q.delete(); end
  endtask

  task automatic test_timeout();
    exp_t e; obs_t o;
    expect_ev(ev(3'd1, 2'd1, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    expect_ev(ev(3'd2, 2'd2, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    tick(); tick();
    expect_ev(ev(3'd0, 2'd0, 0, 0, 0), cyc + 2, 0); tick();
    step(5);
    expect_ev(ev(3'd1, 2'd1, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    expect_ev(ev(3'd2, 2'd2, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    tick(); tick();
    expect_ev(ev(3'd2, 2'd2, 1, 0, 1), cyc + 6, 1);
    expect_ev(ev(3'd2, 2'd2, 1, 0, 0), cyc + 7, 1); press(0, 1, 0);
    tick(); tick(); step(10);
    expect_ev(ev(3'd0, 2'd0, 0, 0, 0), cyc + 2, 0); tick();
    step(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL timeout missing: got none want %h", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc < e.cyc - e.tol || o.cyc > e.cyc + e.tol) begin
          n_err++; $display("FAIL timeout: got %h@%0d want %h@%0d", o.vec, o.cyc, e.vec, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL timeout extra: got %h want none", obs_q[0].vec); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o;
    expect_ev(ev(3'd1, 2'd1, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    expect_ev(ev(3'd2, 2'd2, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    expect_ev(ev(3'd3, 2'd3, 1, 0, 0), cyc + 6, 1); press(1, 0, 0);
    expect_ev(ev(3'd3, 2'd3, 1, 0, 1), cyc + 6, 1);
    btn_set = 1'b1;
    for (int i = 0; i < 20 && inc_pulse !== 1'b1; i++) step(1);
    n_cmp++;
    if (inc_pulse !== 1'b1) begin n_err++; $display("FAIL reset_mid inc_wait: got %b want 1", inc_pulse); end
    #2 rst_n = 1'b0; #1;
    n_cmp++;
    if (outv() !== 8'h00) begin n_err++; $display("FAIL reset_mid assert: got %h want 00", outv()); end
    prev_v = 8'h00;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL reset_mid missing: got none want %h", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.cyc < e.cyc - e.tol || o.cyc > e.cyc + e.tol) begin
          n_err++; $display("FAIL reset_mid: got %h@%0d want %h@%0d", o.vec, o.cyc, e.vec, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL reset_mid extra: got %h want none", obs_q[0].vec); obs_q.delete(); end
    step(3);
    rst_n = 1'b1;
    step(20);
    btn_set = 1'b0;
    step(10);
    n_cmp++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_mid state: got %0d want 0", state_o); end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL reset_mid post: got %h want none", obs_q[0].vec); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_mode_enter();
    test_set_inc();
    test_mode_cycle();
    test_debug();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
